// File: rtl/bb_pkg.sv
// Shared constants, state encoding and helpers for the ball direction controller.
package bb_pkg;

    // Playfield geometry
    localparam int unsigned SCR_W       = 160;
    localparam int unsigned SCR_H       = 120;
    localparam int unsigned PADDLE_Y    = 112;
    localparam int unsigned PADDLE_W    = 16;

    // Brick map handshake
    localparam int unsigned ACK_TIMEOUT = 15;
    localparam int unsigned TO_W        = $clog2(ACK_TIMEOUT + 1);

    // Coordinate widths
    localparam int unsigned X_W         = 8;
    localparam int unsigned Y_W         = 7;

    // Controller states
    typedef enum logic [2:0] {
        IDLE,
        WALL,
        QX,
        QY,
        COMMIT,
        LOST
    } state_t;

    // Brick map query address
    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pix_t;

    // One pixel step along x in the given direction
    function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] v, input logic up);
        return up ? v + X_W'(1) : v - X_W'(1);
    endfunction

    // One pixel step along y in the given direction
    function automatic logic [Y_W-1:0] step_y(input logic [Y_W-1:0] v, input logic up);
        return up ? v + Y_W'(1) : v - Y_W'(1);
    endfunction

endpackage

// File: rtl/ball_dir_ctrl_brick_query.sv
// Brick map req/ack handshake with timeout and a one-cycle clear pulse on hit.
module brick_query
    import bb_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  pix_t           start_pix,
    input  logic           brick_ack,
    input  logic           brick_hit,
    output logic           brick_req,
    output logic [X_W-1:0] brick_qx,
    output logic [Y_W-1:0] brick_qy,
    output logic           brick_clr,
    output logic           done_c,
    output logic           hit_c
);

    logic [TO_W-1:0] wait_cnt;
    logic            ack_c;
    logic            timeout_c;

    // Completion: a real answer, or the wait budget used up with no answer
    always_comb begin
        ack_c     = brick_req & brick_ack;
        timeout_c = brick_req & ~brick_ack & (wait_cnt == TO_W'(ACK_TIMEOUT - 1));
        done_c    = ack_c | timeout_c;
        hit_c     = ack_c & brick_hit;
    end

    // Request, address hold and wait counter; address stays put after done so clear targets it
    always_ff @(posedge clk) begin
        if (reset) begin
            brick_req <= 1'b0;
            brick_qx  <= '0;
            brick_qy  <= '0;
            brick_clr <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            brick_clr <= hit_c;
            if (start) begin
                brick_req <= 1'b1;
                brick_qx  <= start_pix.x;
                brick_qy  <= start_pix.y;
                wait_cnt  <= '0;
            end else if (done_c) begin
                brick_req <= 1'b0;
                wait_cnt  <= '0;
            end else if (brick_req) begin
                wait_cnt  <= wait_cnt + TO_W'(1);
            end
        end
    end

endmodule

// File: rtl/ball_dir_ctrl.sv
// Ball direction controller: walls, paddle, brick queries and ball loss, one decision per step.
module ball_dir_ctrl
    import bb_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           step,
    input  logic [X_W-1:0] ball_x,
    input  logic [Y_W-1:0] ball_y,
    input  logic [X_W-1:0] paddle_x,
    input  logic           brick_ack,
    input  logic           brick_hit,
    output logic           brick_req,
    output logic [X_W-1:0] brick_qx,
    output logic [Y_W-1:0] brick_qy,
    output logic           brick_clr,
    output logic           x_du,
    output logic           y_du,
    output logic           move,
    output logic           ball_lost,
    output logic           busy
);

    state_t         state;
    state_t         state_nxt;

    // Snapshot of the inputs taken when the step is accepted
    logic [X_W-1:0] x_r;
    logic [Y_W-1:0] y_r;
    logic [X_W-1:0] px_r;

    // Wall / paddle decision
    logic [X_W:0]   x9_c;
    logic [X_W:0]   px9_c;
    logic           pad_span_c;
    logic           x_flip_c;
    logic           x_du_wall_c;
    logic           y_du_wall_c;
    logic           lost_c;

    // Query port
    logic           q_start_c;
    pix_t           q_pix_c;
    logic           q_done_c;
    logic           q_hit_c;

    // Next values of registered outputs
    logic           x_du_nxt;
    logic           y_du_nxt;
    logic           move_nxt;
    logic           lost_nxt;
    logic           busy_nxt;

    // Wall and paddle rules on the latched position; paddle span compared one bit wider to avoid wrap
    always_comb begin
        x9_c        = {1'b0, x_r};
        px9_c       = {1'b0, px_r};
        pad_span_c  = (x9_c >= px9_c) && (x9_c < px9_c + (X_W + 1)'(PADDLE_W));
        x_flip_c    = (x_du && (x_r == X_W'(SCR_W - 1))) || (!x_du && (x_r == '0));
        x_du_wall_c = x_du ^ x_flip_c;
        if (!y_du && (y_r == '0)) begin
            y_du_wall_c = 1'b1;
        end else if (y_du && (y_r == Y_W'(PADDLE_Y - 1)) && pad_span_c) begin
            y_du_wall_c = 1'b0;
        end else begin
            y_du_wall_c = y_du;
        end
        lost_c      = y_du && (y_r == Y_W'(SCR_H - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (step) state_nxt = WALL;
            WALL:    state_nxt = lost_c ? LOST : QX;
            QX:      if (q_done_c) state_nxt = QY;
            QY:      if (q_done_c) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            LOST:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: direction updates, query launches and strobe next values
    always_comb begin
        x_du_nxt  = x_du;
        y_du_nxt  = y_du;
        q_start_c = 1'b0;
        q_pix_c   = '0;
        unique case (state)
            WALL: begin
                if (lost_c) begin
                    x_du_nxt = 1'b1;
                    y_du_nxt = 1'b0;
                end else begin
                    x_du_nxt  = x_du_wall_c;
                    y_du_nxt  = y_du_wall_c;
                    q_start_c = 1'b1;
                    q_pix_c.x = step_x(x_r, x_du_wall_c);
                    q_pix_c.y = y_r;
                end
            end
            QX: begin
                if (q_hit_c) x_du_nxt = ~x_du;
            end
            QY: begin
                // Request is low only in the first QY cycle, while the x query's clear address is still held
                if (!brick_req) begin
                    q_start_c = 1'b1;
                    q_pix_c.x = x_r;
                    q_pix_c.y = step_y(y_r, y_du);
                end
                if (q_hit_c) y_du_nxt = ~y_du;
            end
            default: begin
            end
        endcase
        move_nxt = (state_nxt == COMMIT);
        lost_nxt = (state_nxt == LOST);
        busy_nxt = (state_nxt != IDLE);
    end

    // Input snapshot and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            x_r       <= '0;
            y_r       <= '0;
            px_r      <= '0;
            x_du      <= 1'b1;
            y_du      <= 1'b0;
            move      <= 1'b0;
            ball_lost <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if ((state == IDLE) && step) begin
                x_r  <= ball_x;
                y_r  <= ball_y;
                px_r <= paddle_x;
            end
            x_du      <= x_du_nxt;
            y_du      <= y_du_nxt;
            move      <= move_nxt;
            ball_lost <= lost_nxt;
            busy      <= busy_nxt;
        end
    end

    // Shared brick map query engine
    brick_query u_query (
        .clk       (clk),
        .reset     (reset),
        .start     (q_start_c),
        .start_pix (q_pix_c),
        .brick_ack (brick_ack),
        .brick_hit (brick_hit),
        .brick_req (brick_req),
        .brick_qx  (brick_qx),
        .brick_qy  (brick_qy),
        .brick_clr (brick_clr),
        .done_c    (q_done_c),
        .hit_c     (q_hit_c)
    );

endmodule
